mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage directly downstream of the GPR read ports. It consumes the rs/rt read values for MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds results in HI/LO for MFHI/MFLO. It raises busy so hazard control can stall dependent instructions.

Parameters:
MUL_CYCLES, 5, multiply latency in cycles from accepted start to result; legal range 1..32
DIV_CYCLES, 32, fixed; radix-2 iterative divider, one quotient bit per cycle; not overridable

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
start  input  1  operation request, sampled on posedge
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
rs_val  input  32  operand A (GPR Rd1); dividend; MTHI/MTLO source
rt_val  input  32  operand B (GPR Rd2); divisor
flush  input  1  cancel in-flight operation (exception/branch squash)
busy  output  1  registered; 1 while a MULT/DIV is in flight
hi  output  32  registered HI
lo  output  32  registered LO

Behaviour:
- Reset: when rst=1 at a posedge: hi=0, lo=0, busy=0, FSM=IDLE, counter=0. Overrides all other inputs, including mid-operation.
- FSM states: IDLE, MUL, DIV.
- Accept: start=1, busy=0, flush=0 at edge N.
- start with busy=1 is ignored, with no effect on the in-flight op. Upstream must stall on busy.
- Reserved op values are ignored; the FSM stays IDLE.
- MTHI/MTLO: hi<=rs_val (or lo<=rs_val) at edge N. busy stays 0, so the new value is visible in cycle N+1.
- MULT/MULTU at edge N:
  - Latch operands; IDLE->MUL; busy=1 from edge N.
  - Full 64-bit product: signed for MULT, unsigned for MULTU.
  - At edge N+MUL_CYCLES: {hi,lo}<=product; busy<=0; MUL->IDLE.
  - busy is high for exactly MUL_CYCLES cycles.
- DIV/DIVU at edge N:
  - Latch operands; IDLE->DIV; busy=1.
  - Signed ops convert operands to magnitudes and record the result signs.
  - One restoring step per cycle, 32 steps.
  - At edge N+32: lo<=quotient, hi<=remainder; busy<=0; DIV->IDLE.
- Signed division rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- Divide by zero (rt_val=0, DIV or DIVU): the full 32 cycles run, busy behaves normally, and hi/lo are left unchanged at completion.
- hi/lo change only at completion, at MTHI/MTLO, or at reset. They hold their old values throughout busy.
- flush=1 at a posedge:
  - Aborts any in-flight op: busy<=0, FSM->IDLE, hi/lo unchanged.
  - flush and start in the same cycle: flush wins and start is ignored.
  - flush on the completing edge: the result is discarded.
- Back-to-back ops: a new start is accepted in the first cycle busy=0, i.e. the cycle after completion.
- Counter width: 6 bits, counting down from latency to 1. It is never read outside the FSM.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIVU 100/7 -> busy 32 cycles; lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (each visible next cycle), then DIV x/0 -> busy 32 cycles; hi=0x11, lo=0x22 unchanged.
- DIV started with flush asserted at cycle 10 -> busy=0 the next cycle, hi/lo unchanged. Then MULT 2*3 -> hi=0, lo=6.
- MULT in flight with start op=MTHI at cycle 2 -> ignored, final hi/lo equal the product. rst at cycle 3 of a DIV -> hi=lo=0, busy=0 next cycle.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiplies complete after MUL_CYCLES; divides run a 32-step restoring loop.
module mdu_hilo #(
   parameter int MUL_CYCLES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [1:0]  dbg_state
);

   localparam int DIV_CYCLES = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   // Handshake: start is taken only at an edge where busy=0 and flush=0;
   // otherwise it is dropped. Upstream holds the instruction while busy=1.
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] rem_q, rem_d;
   logic        sgn_q, sgn_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [63:0] a_ext, b_ext, prod;
   logic [32:0] shifted, diff;
   logic [31:0] step_rem, step_quo;
   logic        div_sgn;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_sgn = (op == OP_DIV);

      a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
      b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
      prod  = a_ext * b_ext;

      // During DIV, a_q shifts dividend bits out and quotient bits in.
      shifted  = {rem_q, a_q[31]};
      diff     = shifted - {1'b0, b_q};
      step_rem = diff[32] ? shifted[31:0] : diff[31:0];
      step_quo = {a_q[30:0], ~diff[32]};

      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     a_d     = rs_val;
                     b_d     = rt_val;
                     sgn_d   = (op == OP_MULT);
                     cnt_d   = 6'(MUL_CYCLES);
                     state_d = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     a_d     = (div_sgn && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
                     b_d     = (div_sgn && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
                     rem_d   = '0;
                     sgn_d   = div_sgn;
                     qneg_d  = div_sgn && (rs_val[31] ^ rt_val[31]);
                     rneg_d  = div_sgn && rs_val[31];
                     dz_d    = (rt_val == 32'd0);
                     cnt_d   = 6'(DIV_CYCLES);
                     state_d = S_DIV;
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (cnt_q == 6'd1) begin
               {hi_d, lo_d} = prod;
               cnt_d        = '0;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         S_DIV: begin
            a_d   = step_quo;
            rem_d = step_rem;
            if (cnt_q == 6'd1) begin
               if (!dz_q) begin
                  lo_d = qneg_q ? (~step_quo + 32'd1) : step_quo;
                  hi_d = rneg_q ? (~step_rem + 32'd1) : step_rem;
               end
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A squash abandons any in-flight result, including one completing now.
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   assign busy      = busy_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases with literal expectations,
// then randomized traffic compared each cycle against a behavioural model.
module tb_mdu_hilo;

   localparam int MUL = 5;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        busy;
   logic [31:0] hi, lo;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_err    = 0;
   bit check_en = 1'b0;

   mdu_hilo #(.MUL_CYCLES(MUL)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
      .busy(busy), .hi(hi), .lo(lo), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [63:0] exp_q[$];     // pending {hi,lo} result of the in-flight op
   bit          m_busy;
   int          m_left;
   bit          m_wr;
   logic [31:0] m_hi, m_lo;

   function automatic logic [63:0] model_mul(bit sgn, logic [31:0] a, logic [31:0] b);
      longint x, y;
      x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
      y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
      return 64'(x * y);
   endfunction

   function automatic logic [63:0] model_div(bit sgn, logic [31:0] a, logic [31:0] b);
      longint x, y, q, r;
      x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
      y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
      if (y == 0) return 64'h0;
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_hi = '0; m_lo = '0; m_busy = 0; m_left = 0; exp_q.delete();
      end else if (flush) begin
         m_busy = 0; exp_q.delete();
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 0;
            if (m_wr) {m_hi, m_lo} = exp_q[0];
            exp_q.delete();
         end
      end else if (start) begin
         case (op)
            3'd0, 3'd1: begin
               exp_q.push_back(model_mul(op == 3'd0, rs_val, rt_val));
               m_wr = 1; m_busy = 1; m_left = MUL;
            end
            3'd2, 3'd3: begin
               exp_q.push_back(model_div(op == 3'd2, rs_val, rt_val));
               m_wr = (rt_val != 0); m_busy = 1; m_left = 32;
            end
            3'd4: m_hi = rs_val;
            3'd5: m_lo = rs_val;
            default: ;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("model_busy", {31'h0, busy}, {31'h0, m_busy});
         check("model_hi", hi, m_hi);
         check("model_lo", lo, m_lo);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1; op = o; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      if (cyc >= 200) begin
         n_checks++;
         n_err++;
         $display("FAIL wait_idle: busy still high after %0d cycles", cyc);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      rst = 1; start = 0; flush = 0; op = '0; rs_val = '0; rt_val = '0;
      repeat (2) @(negedge clk);
      rst = 0;
      check_en = 1;
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);

      issue(3'd0, 32'hFFFF_FFFD, 32'd7);
      wait_idle(cyc);
      check("mult_busy_cycles", cyc, 32'd5);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFEB);

      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(cyc);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      issue(3'd3, 32'd100, 32'd7);
      wait_idle(cyc);
      check("divu_busy_cycles", cyc, 32'd32);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle(cyc);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);

      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(cyc);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'h0);

      issue(3'd4, 32'h11, 32'h0);
      check("mthi_next", hi, 32'h11);
      issue(3'd5, 32'h22, 32'h0);
      check("mtlo_next", lo, 32'h22);
      issue(3'd2, 32'd1234, 32'd0);
      wait_idle(cyc);
      check("divz_busy_cycles", cyc, 32'd32);
      check("divz_hi", hi, 32'h11);
      check("divz_lo", lo, 32'h22);

      issue(3'd2, 32'd1000, 32'd3);
      repeat (8) @(negedge clk);
      flush = 1;
      @(negedge clk);
      flush = 0;
      check("flush_busy", {31'h0, busy}, 32'h0);
      check("flush_hi", hi, 32'h11);
      check("flush_lo", lo, 32'h22);
      issue(3'd0, 32'd2, 32'd3);
      wait_idle(cyc);
      check("after_flush_hi", hi, 32'h0);
      check("after_flush_lo", lo, 32'd6);

      issue(3'd0, 32'd9, 32'd4);
      start = 1; op = 3'd4; rs_val = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 0;
      wait_idle(cyc);
      check("ignored_mthi_hi", hi, 32'h0);
      check("ignored_mthi_lo", lo, 32'd36);

      issue(3'd4, 32'h55, 32'h0);
      issue(3'd2, 32'd50, 32'd5);
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("rst_mid_busy", {31'h0, busy}, 32'h0);
      check("rst_mid_hi", hi, 32'h0);
      check("rst_mid_lo", lo, 32'h0);

      issue(3'd0, 32'd5, 32'd5);
      repeat (4) @(negedge clk);
      flush = 1;
      @(negedge clk);
      flush = 0;
      check("flush_done_busy", {31'h0, busy}, 32'h0);
      check("flush_done_lo", lo, 32'h0);

      start = 1; op = 3'd4; rs_val = 32'h77; flush = 1;
      @(negedge clk);
      start = 0; flush = 0;
      check("flush_start_hi", hi, 32'h0);
      issue(3'd6, 32'h99, 32'h1);
      check("reserved6_busy", {31'h0, busy}, 32'h0);
      issue(3'd7, 32'h99, 32'h1);
      check("reserved7_busy", {31'h0, busy}, 32'h0);
      check("reserved_hi", hi, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst    = ($urandom_range(0, 599) == 0);
         flush  = ($urandom_range(0, 39) == 0);
         start  = ($urandom_range(0, 2) != 0);
         op     = 3'($urandom_range(0, 7));
         rs_val = pick();
         rt_val = pick();
      end
      @(negedge clk);
      rst = 0; flush = 0; start = 0;
      wait_idle(cyc);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
